// File: rtl/apb_slave_regfile_pkg.sv
// Shared types for the APB register-file completer: FSM encoding and wait-counter width.
package apb_slave_regfile_pkg;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/apb_slave_regfile_regs.sv
// Byte-strobed register array with combinational read; word 0 is a hard-wired ID constant.
module apb_slave_regfile_regs
   import apb_slave_regfile_pkg::*;
#(
   parameter int                    DATA_WIDTH    = 32,
   parameter int                    ADDRESS_WIDTH = 4,
   parameter int                    STRB_WIDTH    = 4,
   parameter int                    NUM_REGS      = 8,
   parameter logic [DATA_WIDTH-1:0] ID_VALUE      = 32'hA5B0_0001
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we,
   input  logic [ADDRESS_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0]    wdata,
   input  logic [STRB_WIDTH-1:0]    wstrb,
   input  logic [ADDRESS_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0]    rdata
);

   // Only words 1..NUM_REGS-1 hold state; word 0 never has storage.
   logic [DATA_WIDTH-1:0] mem_q [1:NUM_REGS-1];
   logic [DATA_WIDTH-1:0] mem_d [1:NUM_REGS-1];

   always_comb begin
      mem_d = mem_q;
      for (int w = 1; w < NUM_REGS; w++) begin
         if (we && (waddr == ADDRESS_WIDTH'(w))) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
               if (wstrb[b]) mem_d[w][8*b +: 8] = wdata[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int w = 1; w < NUM_REGS; w++) mem_q[w] <= '0;
      end else begin
         mem_q <= mem_d;
      end
   end

   always_comb begin
      rdata = '0;
      if (raddr == '0) rdata = ID_VALUE;
      for (int w = 1; w < NUM_REGS; w++) begin
         if (raddr == ADDRESS_WIDTH'(w)) rdata = mem_q[w];
      end
   end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer: captures the setup phase, counts wait states, and completes with
// registered PREADY/PSLVERR/PRDATA; writes commit on the closing edge of the transfer.
module apb_slave_regfile
   import apb_slave_regfile_pkg::*;
#(
   parameter int                    DATA_WIDTH    = 32,
   parameter int                    ADDRESS_WIDTH = 4,
   parameter int                    STRB_WIDTH    = 4,
   parameter int                    NUM_REGS      = 8,
   parameter int                    WAIT_STATES   = 0,
   parameter logic [DATA_WIDTH-1:0] ID_VALUE      = 32'hA5B0_0001
) (
   input  logic                     PCLK,
   input  logic                     PRESET,
   input  logic                     PSEL,
   input  logic                     PENABLE,
   input  logic                     PWRITE,
   input  logic [ADDRESS_WIDTH-1:0] PADDR,
   input  logic [DATA_WIDTH-1:0]    PWDATA,
   input  logic [STRB_WIDTH-1:0]    PSTRB,
   output logic [DATA_WIDTH-1:0]    PRDATA,
   output logic                     PREADY,
   output logic                     PSLVERR,
   output logic [1:0]               dbg_state
);

   localparam logic [CNT_W-1:0]       CNT_INIT   = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
   localparam logic [ADDRESS_WIDTH:0] NUM_REGS_V = (ADDRESS_WIDTH+1)'(NUM_REGS);

   state_e                     state_q,   state_d;
   logic [CNT_W-1:0]           cnt_q,     cnt_d;
   logic [ADDRESS_WIDTH-1:0]   addr_q,    addr_d;
   logic                       write_q,   write_d;
   logic [DATA_WIDTH-1:0]      wdata_q,   wdata_d;
   logic [STRB_WIDTH-1:0]      strb_q,    strb_d;
   logic                       err_q,     err_d;
   logic                       pready_q,  pready_d;
   logic                       pslverr_q, pslverr_d;
   logic [DATA_WIDTH-1:0]      prdata_q,  prdata_d;

   logic                       err_setup;
   logic                       reg_we;
   logic [ADDRESS_WIDTH-1:0]   rd_addr;
   logic [DATA_WIDTH-1:0]      rd_data;

   assign err_setup = ({1'b0, PADDR} >= NUM_REGS_V) || (PWRITE && (PADDR == '0));

   apb_slave_regfile_regs #(
      .DATA_WIDTH    (DATA_WIDTH),
      .ADDRESS_WIDTH (ADDRESS_WIDTH),
      .STRB_WIDTH    (STRB_WIDTH),
      .NUM_REGS      (NUM_REGS),
      .ID_VALUE      (ID_VALUE)
   ) u_regs (
      .clk   (PCLK),
      .rst   (PRESET),
      .we    (reg_we),
      .waddr (addr_q),
      .wdata (wdata_q),
      .wstrb (strb_q),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      write_d   = write_q;
      wdata_d   = wdata_q;
      strb_d    = strb_q;
      err_d     = err_q;
      pready_d  = 1'b0;
      pslverr_d = 1'b0;
      prdata_d  = '0;
      reg_we    = 1'b0;
      rd_addr   = addr_q;
      case (state_q)
         ST_IDLE: begin
            // With zero wait states the completion data comes straight from the setup-phase bus.
            rd_addr = PADDR;
            if (PSEL && !PENABLE) begin
               addr_d  = PADDR;
               write_d = PWRITE;
               wdata_d = PWDATA;
               strb_d  = PSTRB;
               err_d   = err_setup;
               if (WAIT_STATES == 0) begin
                  state_d   = ST_DONE;
                  pready_d  = 1'b1;
                  pslverr_d = err_setup;
                  prdata_d  = (!PWRITE && !err_setup) ? rd_data : '0;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         ST_WAIT: begin
            if (!PSEL) begin
               state_d = ST_IDLE;
            end else if (PENABLE) begin
               if (cnt_q == '0) begin
                  state_d   = ST_DONE;
                  pready_d  = 1'b1;
                  pslverr_d = err_q;
                  prdata_d  = (!write_q && !err_q) ? rd_data : '0;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
         end
         ST_DONE: begin
            // A master that drops PSEL here has aborted; nothing is committed.
            state_d = ST_IDLE;
            reg_we  = PSEL && write_q && !err_q;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         write_q   <= 1'b0;
         wdata_q   <= '0;
         strb_q    <= '0;
         err_q     <= 1'b0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         write_q   <= write_d;
         wdata_q   <= wdata_d;
         strb_q    <= strb_d;
         err_q     <= err_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
         prdata_q  <= prdata_d;
      end
   end

   assign PREADY    = pready_q;
   assign PSLVERR   = pslverr_q;
   assign PRDATA    = prdata_q;
   assign dbg_state = state_q;

endmodule
